// File: rtl/e_mdu_issue_if.sv
// E-stage MDU issue bundle: E/D op codes in, start/ctr/hazard flags out.
// Perf counter signals exist only when MDU_PERF_EN is defined.
interface e_mdu_issue_if;
  logic       e_valid_i;
  logic [3:0] e_op_i;
  logic [3:0] d_op_i;
  logic       mdu_start_o;
  logic [3:0] mdu_ctr_o;
  logic       busy_o;
  logic       stall_o;
  logic       err_o;
`ifdef MDU_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] issue_cnt_o;
`endif

  modport master (
    output e_valid_i, e_op_i, d_op_i,
    input  mdu_start_o, mdu_ctr_o, busy_o, stall_o, err_o
`ifdef MDU_PERF_EN
    , input stall_cnt_o, issue_cnt_o
`endif
  );

  modport slave (
    input  e_valid_i, e_op_i, d_op_i,
    output mdu_start_o, mdu_ctr_o, busy_o, stall_o, err_o
`ifdef MDU_PERF_EN
    , output stall_cnt_o, issue_cnt_o
`endif
  );
endinterface

// File: rtl/e_mdu_issue.sv
// E-stage MDU issue/hazard controller with its own latency counter.
// Optional MDU_PERF_EN adds stall/issue cycle counters.
module e_mdu_issue #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  e_mdu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;

  logic       w_e_mul;
  logic       w_e_div;
  logic       w_e_mt;
  logic       w_e_mdu;
  logic       w_d_mdu;
  logic       w_busy;
  logic       w_start;
  logic [3:0] w_ctr;

  assign w_e_mul = (bus.e_op_i == 4'd1) || (bus.e_op_i == 4'd2);
  assign w_e_div = (bus.e_op_i == 4'd3) || (bus.e_op_i == 4'd4);
  assign w_e_mt  = (bus.e_op_i == 4'd7) || (bus.e_op_i == 4'd8);
  // Reserved codes 9..15 count as no-op on both ports.
  assign w_e_mdu = (bus.e_op_i != 4'd0) && (bus.e_op_i <= 4'd8);
  assign w_d_mdu = (bus.d_op_i != 4'd0) && (bus.d_op_i <= 4'd8);
  assign w_busy  = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_ctr       = 4'd0;
    unique case (r_state)
      IDLE: begin
        if (bus.e_valid_i && !reset) begin
          unique case (1'b1)
            w_e_mul: begin
              w_start     = 1'b1;
              w_ctr       = bus.e_op_i;
              w_state_nxt = MUL_RUN;
              w_cnt_nxt   = MUL_CNT;
            end
            w_e_div: begin
              w_start     = 1'b1;
              w_ctr       = bus.e_op_i;
              w_state_nxt = DIV_RUN;
              w_cnt_nxt   = DIV_CNT;
            end
            w_e_mt: begin
              w_ctr = bus.e_op_i;
            end
            default: begin
              w_ctr = 4'd0;
            end
          endcase
        end
      end
      MUL_RUN, DIV_RUN: begin
        w_cnt_nxt = r_cnt - ONE;
        if (r_cnt == ONE) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (bus.e_valid_i && w_e_mdu && w_busy) begin
      r_err <= 1'b1;
    end
  end

  assign bus.mdu_start_o = w_start;
  assign bus.mdu_ctr_o   = w_ctr;
  assign bus.busy_o      = w_busy;
  assign bus.stall_o     = w_d_mdu && (w_start || w_busy);
  assign bus.err_o       = r_err;

`ifdef MDU_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_issue_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_issue_cnt <= '0;
    end else begin
      if (bus.stall_o) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_start)     r_issue_cnt <= r_issue_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.issue_cnt_o = r_issue_cnt;
`endif

endmodule

// File: tb/tb_e_mdu_issue.sv
// Directed bench for e_mdu_issue: latency windows, stalls, mt ops, errors.
// Define MDU_PERF_EN to also exercise the perf counters.
module tb_e_mdu_issue;
  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  e_mdu_issue_if bus ();

  e_mdu_issue #(
    .MULT_LAT(5),
    .DIV_LAT (10),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] eop,
                       input logic [3:0] dop);
    bus.e_valid_i = v;
    bus.e_op_i    = eop;
    bus.d_op_i    = dop;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 4'd0);
    reset = 1'b1;
    next_cyc();
    next_cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.e_valid_i = 1'b0;
    bus.e_op_i    = 4'd0;
    bus.d_op_i    = 4'd0;
    do_reset();

    chk("rst_busy",  32'(bus.busy_o), 0);
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_start", 32'(bus.mdu_start_o), 0);
    chk("rst_ctr",   32'(bus.mdu_ctr_o), 0);
    chk("rst_err",   32'(bus.err_o), 0);

    // mult: pulse cycle 0, busy 1..5, idle 6, then back-to-back multu
    drive(1'b1, 4'd1, 4'd0);
    chk("mul_start0", 32'(bus.mdu_start_o), 1);
    chk("mul_ctr0",   32'(bus.mdu_ctr_o), 1);
    chk("mul_busy0",  32'(bus.busy_o), 0);
    for (int c = 1; c <= 5; c++) begin
      next_cyc();
      drive(1'b0, 4'd1, 4'd0);
      chk($sformatf("mul_busy%0d", c), 32'(bus.busy_o), 1);
      chk($sformatf("mul_start%0d", c), 32'(bus.mdu_start_o), 0);
    end
    next_cyc();
    drive(1'b1, 4'd2, 4'd0);
    chk("mul_busy6",  32'(bus.busy_o), 0);
    chk("b2b_start",  32'(bus.mdu_start_o), 1);
    chk("b2b_ctr",    32'(bus.mdu_ctr_o), 2);
    next_cyc();
    drive(1'b0, 4'd0, 4'd0);
    chk("b2b_busy",   32'(bus.busy_o), 1);
    chk("b2b_err",    32'(bus.err_o), 0);
    do_reset();

    // divu with mflo in D: stall 0..10, clear at 11
    drive(1'b1, 4'd4, 4'd6);
    chk("divu_stall0", 32'(bus.stall_o), 1);
    chk("divu_ctr0",   32'(bus.mdu_ctr_o), 4);
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      drive(1'b0, 4'd0, 4'd6);
      chk($sformatf("divu_stall%0d", c), 32'(bus.stall_o), 1);
    end
    next_cyc();
    drive(1'b0, 4'd0, 4'd6);
    chk("divu_stall11", 32'(bus.stall_o), 0);
    chk("divu_busy11",  32'(bus.busy_o), 0);
    do_reset();

    // div with non-MDU / reserved op in D: never stalls
    drive(1'b1, 4'd3, 4'd0);
    chk("div_nst0", 32'(bus.stall_o), 0);
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      drive(1'b0, 4'd0, (c == 4) ? 4'hA : 4'd0);
      chk($sformatf("div_nst%0d", c), 32'(bus.stall_o), 0);
      chk($sformatf("div_busy%0d", c), 32'(bus.busy_o), 1);
    end
    do_reset();

    // reset held 3 cycles mid-div
    drive(1'b1, 4'd3, 4'd0);
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      drive(1'b0, 4'd0, 4'd5);
    end
    chk("mid_busy_pre", 32'(bus.busy_o), 1);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) next_cyc();
    reset = 1'b0;
    drive(1'b0, 4'd0, 4'd5);
    chk("mid_busy",  32'(bus.busy_o), 0);
    chk("mid_stall", 32'(bus.stall_o), 0);
    chk("mid_cnt",   32'(dut.r_cnt), 0);

    // mtlo idle, mfhi / invalid / reserved never issue
    drive(1'b1, 4'd8, 4'd0);
    chk("mtlo_ctr",   32'(bus.mdu_ctr_o), 8);
    chk("mtlo_start", 32'(bus.mdu_start_o), 0);
    next_cyc();
    drive(1'b1, 4'd5, 4'd0);
    chk("mtlo_busy",  32'(bus.busy_o), 0);
    chk("mfhi_ctr",   32'(bus.mdu_ctr_o), 0);
    drive(1'b0, 4'd1, 4'd0);
    chk("nv_start",   32'(bus.mdu_start_o), 0);
    chk("nv_ctr",     32'(bus.mdu_ctr_o), 0);
    drive(1'b1, 4'hF, 4'hC);
    chk("rsv_start",  32'(bus.mdu_start_o), 0);
    chk("rsv_ctr",    32'(bus.mdu_ctr_o), 0);
    chk("rsv_stall",  32'(bus.stall_o), 0);

    // mult forced in E during busy: no issue, sticky err
    drive(1'b1, 4'd1, 4'd0);
    next_cyc();
    drive(1'b1, 4'd1, 4'd0);
    chk("frc_start", 32'(bus.mdu_start_o), 0);
    chk("frc_ctr",   32'(bus.mdu_ctr_o), 0);
    next_cyc();
    drive(1'b0, 4'd0, 4'd0);
    chk("frc_err",   32'(bus.err_o), 1);
    for (int c = 0; c < 6; c++) next_cyc();
    chk("frc_idle",  32'(bus.busy_o), 0);
    chk("err_stick", 32'(bus.err_o), 1);
    do_reset();
    chk("err_clr",   32'(bus.err_o), 0);

`ifdef MDU_PERF_EN
    drive(1'b1, 4'd1, 4'd5);
    for (int c = 1; c <= 5; c++) begin
      next_cyc();
      drive(1'b0, 4'd0, 4'd5);
    end
    next_cyc();
    drive(1'b0, 4'd0, 4'd0);
    next_cyc();
    chk("perf_issue", bus.issue_cnt_o, 1);
    chk("perf_stall", bus.stall_cnt_o, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
